// File: rtl/mem_port_arbiter.sv
// ============================================================================
// mem_port_arbiter: shares one 16-bit RAM port between instruction fetch and
// data access; DM has priority, a starvation counter forces IF through.
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module mem_port_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int STARVE_MAX = 4,
    parameter int CNT_W      = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_if_req,
    input  logic [ADDR_W-1:0] i_if_addr,
    output logic              o_if_ack,
    output logic [DATA_W-1:0] o_if_rdata,
    output logic              o_if_err,
    input  logic              i_dm_req,
    input  logic              i_dm_wr,
    input  logic [ADDR_W-1:0] i_dm_addr,
    input  logic [DATA_W-1:0] i_dm_wdata,
    output logic              o_dm_ack,
    output logic [DATA_W-1:0] o_dm_rdata,
    output logic              o_dm_err,
    output logic              o_mem_enable,
    output logic              o_mem_wr,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata,
    input  logic              i_mem_err,
    input  logic              i_mem_wr_ok,
    output logic              o_busy
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACCESS  = 2'd1,
        S_WAIT_WR = 2'd2,
        S_RESP    = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] C_STARVE_MAX = CNT_W'(STARVE_MAX);

    state_t              r_state;
    state_t              w_next;
    logic                r_owner_dm;
    logic                r_wr;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [CNT_W-1:0]    r_starve_cnt;
    logic [DATA_W-1:0]   r_if_rdata;
    logic                r_if_err;
    logic [DATA_W-1:0]   r_dm_rdata;
    logic                r_dm_err;

    logic                w_idle;
    logic                w_grant_if;
    logic                w_grant_dm;
    logic                w_in_access;
    logic                w_load_res;
    logic [DATA_W-1:0]   w_res_rdata;
    logic                w_res_err;

    always_comb begin
        w_idle      = (r_state == S_IDLE);
        w_grant_if  = w_idle && i_if_req && (!i_dm_req || r_starve_cnt == C_STARVE_MAX);
        w_grant_dm  = w_idle && i_dm_req && !w_grant_if;
        w_next      = r_state;
        case (r_state)
            S_IDLE:    if (w_grant_if || w_grant_dm) w_next = S_ACCESS;
            S_ACCESS:  w_next = (r_wr && !i_mem_err) ? S_WAIT_WR : S_RESP;
            S_WAIT_WR: w_next = S_RESP;
            S_RESP:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase

        // Result is committed to the owner's output registers on entry to RESP
        w_load_res  = ((r_state == S_ACCESS) && (w_next == S_RESP)) || (r_state == S_WAIT_WR);
        w_res_rdata = ((r_state == S_ACCESS) && !r_wr) ? i_mem_rdata : '0;
        w_res_err   = (r_state == S_ACCESS) ? i_mem_err : ~i_mem_wr_ok;

        // rst gating keeps a reset cycle from issuing any RAM write or ack
        w_in_access  = rst && (r_state == S_ACCESS);
        o_mem_enable = w_in_access;
        o_mem_wr     = w_in_access && r_wr;
        o_mem_addr   = w_in_access ? r_addr  : '0;
        o_mem_wdata  = w_in_access ? r_wdata : '0;
        o_if_ack     = rst && (r_state == S_RESP) && !r_owner_dm;
        o_dm_ack     = rst && (r_state == S_RESP) &&  r_owner_dm;
        o_busy       = rst && (r_state != S_IDLE);
        o_if_rdata   = r_if_rdata;
        o_if_err     = r_if_err;
        o_dm_rdata   = r_dm_rdata;
        o_dm_err     = r_dm_err;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_owner_dm   <= 1'b0;
            r_wr         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_starve_cnt <= '0;
            r_if_rdata   <= '0;
            r_if_err     <= 1'b0;
            r_dm_rdata   <= '0;
            r_dm_err     <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_grant_if || w_grant_dm) begin
                r_owner_dm <= w_grant_dm;
                r_addr     <= w_grant_dm ? i_dm_addr : i_if_addr;
                r_wdata    <= w_grant_dm ? i_dm_wdata : '0;
                r_wr       <= w_grant_dm && i_dm_wr;
            end
            if (w_grant_if) begin
                r_starve_cnt <= '0;
            end else if (w_grant_dm) begin
                if (!i_if_req)
                    r_starve_cnt <= '0;
                else if (r_starve_cnt != C_STARVE_MAX)
                    r_starve_cnt <= r_starve_cnt + CNT_W'(1);
            end
            if (w_load_res) begin
                if (r_owner_dm) begin
                    r_dm_rdata <= w_res_rdata;
                    r_dm_err   <= w_res_err;
                end else begin
                    r_if_rdata <= w_res_rdata;
                    r_if_err   <= w_res_err;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// tb_mem_port_arbiter: directed stimulus with a queue-based ack scoreboard
// and a big-endian byte RAM model.
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_mem_port_arbiter;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              if_req, dm_req, dm_wr;
    logic [ADDR_W-1:0] if_addr, dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              if_ack, if_err, dm_ack, dm_err;
    logic [DATA_W-1:0] if_rdata, dm_rdata;
    logic              mem_enable, mem_wr, mem_err, busy;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;
    logic              r_wr_ok;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .STARVE_MAX(4), .CNT_W(3)) u_dut (
        .clk(clk), .rst(rst),
        .i_if_req(if_req), .i_if_addr(if_addr),
        .o_if_ack(if_ack), .o_if_rdata(if_rdata), .o_if_err(if_err),
        .i_dm_req(dm_req), .i_dm_wr(dm_wr), .i_dm_addr(dm_addr), .i_dm_wdata(dm_wdata),
        .o_dm_ack(dm_ack), .o_dm_rdata(dm_rdata), .o_dm_err(dm_err),
        .o_mem_enable(mem_enable), .o_mem_wr(mem_wr), .o_mem_addr(mem_addr),
        .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata), .i_mem_err(mem_err),
        .i_mem_wr_ok(r_wr_ok), .o_busy(busy)
    );

    // RAM model: big-endian, combinational read, write-success flag one cycle later
    logic [7:0] ram [0:255];
    logic [7:0] w_a0, w_a1;
    assign w_a0      = mem_addr[7:0];
    assign w_a1      = w_a0 + 8'd1;
    assign mem_err   = mem_enable & mem_addr[0];
    assign mem_rdata = (mem_enable && !mem_err) ? {ram[w_a0], ram[w_a1]} : 16'h0000;

    always @(posedge clk) begin
        if (!rst) begin
            r_wr_ok <= 1'b0;
        end else begin
            r_wr_ok <= 1'b0;
            if (mem_enable && mem_wr && !mem_err) begin
                ram[w_a0] <= mem_wdata[15:8];
                ram[w_a1] <= mem_wdata[7:0];
                r_wr_ok   <= 1'b1;
            end
        end
    end

    typedef struct packed {
        logic        dm;
        logic [15:0] rdata;
        logic        err;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (if_ack || dm_ack) begin
            if (q.size() == 0) begin
                check("unexpected_ack", {62'd0, dm_ack, if_ack}, 64'd0);
            end else begin
                mon_e = q.pop_front();
                check("ack_port", {62'd0, dm_ack, if_ack}, mon_e.dm ? 64'd2 : 64'd1);
                check("ack_rdata", mon_e.dm ? dm_rdata : if_rdata, mon_e.rdata);
                check("ack_err", mon_e.dm ? dm_err : if_err, mon_e.err);
            end
        end
    end

    // Waits for the requested port's ack; when chk is set the DUT is known idle
    // at issue, so the ACCESS-cycle strobes and the ack latency are checked too.
    task automatic wait_ack(input logic dm, input bit chk, input int exp_lat,
                            input logic wr, input logic [15:0] addr);
        int lat  = 0;
        bit seen = 0;
        while (!seen && lat < 20) begin
            @(negedge clk);
            lat++;
            if (chk && lat == 1)
                check("access_strobe", {mem_enable, mem_wr, mem_addr}, {1'b1, wr, addr});
            seen = dm ? dm_ack : if_ack;
        end
        if (!seen)
            check("ack_timeout", {63'd0, seen}, 64'd1);
        else if (chk)
            check("ack_latency", lat, exp_lat);
    endtask

    task automatic dm_access(input logic wr, input logic [15:0] addr, input logic [15:0] wdata,
                             input logic [15:0] exp_rd, input logic exp_err, input int exp_lat);
        @(negedge clk);
        q.push_back(exp_t'{1'b1, exp_rd, exp_err});
        dm_wr    = wr;
        dm_addr  = addr;
        dm_wdata = wdata;
        dm_req   = 1'b1;
        wait_ack(1'b1, 1'b1, exp_lat, wr, addr);
        dm_req   = 1'b0;
    endtask

    task automatic if_read(input logic [15:0] addr, input logic [15:0] exp_rd, input logic exp_err);
        @(negedge clk);
        q.push_back(exp_t'{1'b0, exp_rd, exp_err});
        if_addr = addr;
        if_req  = 1'b1;
        wait_ack(1'b0, 1'b1, 2, 1'b0, addr);
        if_req  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int acks;
        int cyc;
        for (int i = 0; i < 256; i++) ram[i] <= 8'h00;
        ram[8'h10] <= 8'hBE; ram[8'h11] <= 8'hEF;
        ram[8'h30] <= 8'hA5; ram[8'h31] <= 8'h5A;

        // Reset held with both requests pending
        rst = 1'b0; if_req = 1'b1; dm_req = 1'b1; dm_wr = 1'b0;
        if_addr = 16'h0010; dm_addr = 16'h0010; dm_wdata = 16'h0000;
        q.push_back(exp_t'{1'b1, 16'hBEEF, 1'b0});
        q.push_back(exp_t'{1'b0, 16'hBEEF, 1'b0});
        repeat (2) begin
            @(negedge clk);
            check("reset_ctrl", {if_ack, dm_ack, mem_enable, mem_wr, busy, if_err, dm_err}, 64'd0);
            check("reset_rdata", {if_rdata, dm_rdata}, 64'd0);
            check("reset_mem_bus", {mem_addr, mem_wdata}, 64'd0);
        end
        rst = 1'b1;
        wait_ack(1'b1, 1'b1, 2, 1'b0, 16'h0010);
        dm_req = 1'b0;
        wait_ack(1'b0, 1'b0, 0, 1'b0, 16'h0010);
        if_req = 1'b0;

        // Basic read, write, read-back
        if_read(16'h0010, 16'hBEEF, 1'b0);
        dm_access(1'b1, 16'h0020, 16'h1234, 16'h0000, 1'b0, 3);
        dm_access(1'b0, 16'h0020, 16'h0000, 16'h1234, 1'b0, 2);

        // Unaligned accesses
        dm_access(1'b1, 16'h0021, 16'hAAAA, 16'h0000, 1'b1, 2);
        check("unaligned_wr_ram", {ram[8'h20], ram[8'h21]}, 64'h1234);
        dm_access(1'b0, 16'h0020, 16'h0000, 16'h1234, 1'b0, 2);
        if_read(16'h0003, 16'h0000, 1'b1);
        check("dm_rdata_held", {dm_rdata, dm_err}, {16'h1234, 1'b0});

        // Both ports hammering: starvation guard lets IF through every 5th grant
        @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            if ((k % 5) == 4) q.push_back(exp_t'{1'b0, 16'hBEEF, 1'b0});
            else              q.push_back(exp_t'{1'b1, 16'h1234, 1'b0});
        end
        if_addr = 16'h0010; dm_addr = 16'h0020; dm_wr = 1'b0;
        if_req = 1'b1; dm_req = 1'b1;
        acks = 0; cyc = 0;
        while (acks < 10 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (if_ack || dm_ack) acks++;
        end
        if_req = 1'b0; dm_req = 1'b0;
        check("starve_ack_count", acks, 10);

        // Reset during a write's ACCESS cycle
        @(negedge clk);
        @(negedge clk);
        dm_wr = 1'b1; dm_addr = 16'h0030; dm_wdata = 16'h5555; dm_req = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_abort_strobe", {mem_enable, mem_wr}, 64'd0);
        @(negedge clk);
        rst = 1'b1; dm_req = 1'b0;
        check("reset_abort_busy", {63'd0, busy}, 64'd0);
        repeat (4) @(negedge clk);
        check("reset_abort_ram", {ram[8'h30], ram[8'h31]}, 64'hA55A);
        check("reset_abort_idle", {dm_ack, busy}, 64'd0);

        check("queue_drained", q.size(), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
